// File: rtl/sprite_overlay_if.sv
// ROM fetch bus between the sprite overlay (master) and its sprite ROM (slave).
// Address is combinational; data returns one clock after the address.
interface sprite_overlay_if #(
   parameter int ROW_W = 4,
   parameter int COL_W = 8
);
   logic [ROW_W-1:0] rom_row;
   logic [COL_W-1:0] rom_col;
   logic [11:0]      rom_data;

   modport master (output rom_row, output rom_col, input rom_data);
   modport slave  (input rom_row, input rom_col, output rom_data);
endinterface

// File: rtl/sprite_overlay.sv
// Single ROM-backed sprite drawn over a background pixel stream.
// Position, scale and enable are latched at frame start so a frame never
// tears; output is two clocks behind hCount/vCount/bright/background.
module sprite_overlay #(
   parameter int          SPR_W        = 156,
   parameter int          SPR_H        = 11,
   parameter int          ROW_W        = 4,
   parameter int          COL_W        = 8,
   parameter logic [11:0] KEY_COLOR    = 12'hFFF,
   parameter int          RST_X        = 250,
   parameter int          RST_Y        = 250,
   parameter int          BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        bright,
   input  logic [9:0]  hCount,
   input  logic [9:0]  vCount,
   input  logic [9:0]  pos_x,
   input  logic [9:0]  pos_y,
   input  logic [1:0]  scale,
   input  logic        blink_en,
   input  logic        tint_en,
   input  logic [11:0] tint_color,
   input  logic [11:0] background,
   sprite_overlay_if.master rom,
   output logic [11:0] rgb,
   output logic        sprite_hit,
   output logic        frame_tick
);

   localparam int          BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [11:0] SPR_W12    = 12'(SPR_W);
   localparam logic [11:0] SPR_H12    = 12'(SPR_H);

   logic          frame_start;
   logic          sh_en;
   logic [9:0]    sh_x;
   logic [9:0]    sh_y;
   logic [1:0]    sh_scale;
   logic [BW-1:0] blink_cnt;
   logic          visible;
   logic [11:0]   dx;
   logic [11:0]   dy;
   logic [11:0]   win_w;
   logic [11:0]   win_h;
   logic          in_window;

   logic          on_d;
   logic          bright_d;
   logic [11:0]   background_d;
   logic          tint_en_d;
   logic [11:0]   tint_color_d;

   assign frame_start = (hCount == 10'd0) && (vCount == 10'd0);

   // Latch the per-frame configuration; scale 3 collapses to 4x.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sh_en    <= 1'b0;
         sh_x     <= 10'(RST_X);
         sh_y     <= 10'(RST_Y);
         sh_scale <= 2'd0;
      end else if (frame_start) begin
         sh_en    <= en;
         sh_x     <= pos_x;
         sh_y     <= pos_y;
         sh_scale <= (scale == 2'd3) ? 2'd2 : scale;
      end
   end

   // One-clock pulse following the frame-start pixel.
   always_ff @(posedge clk) begin
      if (!rst) frame_tick <= 1'b0;
      else      frame_tick <= frame_start;
   end

   // Blink: toggle visibility every BLINK_FRAMES frame starts while enabled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         blink_cnt <= '0;
         visible   <= 1'b1;
      end else if (!blink_en) begin
         blink_cnt <= '0;
         visible   <= 1'b1;
      end else if (frame_start) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            visible   <= ~visible;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Window test in 12 bits: the far edge may exceed 1023, which simply
   // never matches a 10-bit counter, so the sprite clips instead of wrapping.
   always_comb begin
      dx        = {2'b00, hCount} - {2'b00, sh_x};
      dy        = {2'b00, vCount} - {2'b00, sh_y};
      win_w     = SPR_W12 << sh_scale;
      win_h     = SPR_H12 << sh_scale;
      in_window = (hCount >= sh_x) && (dx < win_w) &&
                  (vCount >= sh_y) && (dy < win_h);
   end

   assign rom.rom_col = COL_W'(dx >> sh_scale);
   assign rom.rom_row = ROW_W'(dy >> sh_scale);

   // Stage 1: align per-pixel controls with the ROM read latency.
   always_ff @(posedge clk) begin
      if (!rst) begin
         on_d         <= 1'b0;
         bright_d     <= 1'b0;
         background_d <= 12'h000;
         tint_en_d    <= 1'b0;
         tint_color_d <= 12'h000;
      end else begin
         on_d         <= sh_en && visible && in_window;
         bright_d     <= bright;
         background_d <= background;
         tint_en_d    <= tint_en;
         tint_color_d <= tint_color;
      end
   end

   // Stage 2: blanking, colour-key transparency and optional tint.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rgb        <= 12'h000;
         sprite_hit <= 1'b0;
      end else if (!bright_d) begin
         rgb        <= 12'h000;
         sprite_hit <= 1'b0;
      end else if (on_d && (rom.rom_data != KEY_COLOR)) begin
         rgb        <= tint_en_d ? tint_color_d : rom.rom_data;
         sprite_hit <= 1'b1;
      end else begin
         rgb        <= background_d;
         sprite_hit <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sprite_overlay.sv
// Directed bench for sprite_overlay. The ROM model returns {row, col} in
// mode 0 and a single key pixel at (row 2, col 5) over 12'h0F0 in mode 1.
module tb_sprite_overlay;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        bright;
   logic [9:0]  hCount;
   logic [9:0]  vCount;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;
   logic [1:0]  scale;
   logic        blink_en;
   logic        tint_en;
   logic [11:0] tint_color;
   logic [11:0] background;
   logic [11:0] rgb;
   logic        sprite_hit;
   logic        frame_tick;
   logic        rom_mode;

   int n_checks = 0;
   int n_errors = 0;

   sprite_overlay_if #(.ROW_W(4), .COL_W(8)) rom_bus ();

   sprite_overlay #(.BLINK_FRAMES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .bright     (bright),
      .hCount     (hCount),
      .vCount     (vCount),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .scale      (scale),
      .blink_en   (blink_en),
      .tint_en    (tint_en),
      .tint_color (tint_color),
      .background (background),
      .rom        (rom_bus),
      .rgb        (rgb),
      .sprite_hit (sprite_hit),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // Synchronous sprite ROM model.
   always @(posedge clk) begin
      if (rom_mode)
         rom_bus.rom_data <= (rom_bus.rom_row == 4'd2 && rom_bus.rom_col == 8'd5) ? 12'hFFF : 12'h0F0;
      else
         rom_bus.rom_data <= {rom_bus.rom_row, rom_bus.rom_col};
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle_px();
      hCount     = 10'd1023;
      vCount     = 10'd1023;
      bright     = 1'b0;
      background = 12'h000;
   endtask

   // Present one pixel, then check the output two clocks later.
   task automatic check_px(input string tag, input logic [9:0] h, input logic [9:0] v,
                           input logic b, input logic [11:0] bg,
                           input logic [11:0] exp_rgb, input logic exp_hit);
      hCount     = h;
      vCount     = v;
      bright     = b;
      background = bg;
      @(posedge clk); #1;
      idle_px();
      @(posedge clk); #1;
      check_val({tag, " rgb"}, rgb, exp_rgb);
      check_val({tag, " hit"}, sprite_hit, exp_hit);
   endtask

   task automatic frame_start();
      hCount = 10'd0;
      vCount = 10'd0;
      bright = 1'b0;
      @(posedge clk); #1;
      check_val("frame_tick high", frame_tick, 1);
      idle_px();
      @(posedge clk); #1;
      check_val("frame_tick low", frame_tick, 0);
   endtask

   logic blink_exp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      rst        = 1'b0;
      en         = 1'b1;
      pos_x      = 10'd100;
      pos_y      = 10'd50;
      scale      = 2'd0;
      blink_en   = 1'b0;
      tint_en    = 1'b0;
      tint_color = 12'h000;
      rom_mode   = 1'b0;
      idle_px();
      repeat (3) @(posedge clk);
      #1;
      check_val("reset rgb", rgb, 0);
      check_val("reset hit", sprite_hit, 0);
      check_val("reset tick", frame_tick, 0);
      rst = 1'b1;

      // Frame 0: shadow enable still clear after reset.
      check_px("f0 hidden", 10'd100, 10'd50, 1'b1, 12'h123, 12'h123, 1'b0);
      frame_start();

      // Frame 1 at (100,50), 1x.
      hCount = 10'd100; vCount = 10'd50; #1;
      check_val("rom_col origin", rom_bus.rom_col, 0);
      check_val("rom_row origin", rom_bus.rom_row, 0);
      check_px("origin", 10'd100, 10'd50, 1'b1, 12'h123, 12'h000, 1'b1);
      check_px("inner", 10'd110, 10'd53, 1'b1, 12'h123, 12'h30A, 1'b1);
      check_px("left edge", 10'd99, 10'd50, 1'b1, 12'h123, 12'h123, 1'b0);
      check_px("right edge", 10'd256, 10'd50, 1'b1, 12'h123, 12'h123, 1'b0);
      check_px("last px", 10'd255, 10'd60, 1'b1, 12'h123, 12'hA9B, 1'b1);
      check_px("bottom edge", 10'd100, 10'd61, 1'b1, 12'h123, 12'h123, 1'b0);
      check_px("blank", 10'd110, 10'd53, 1'b0, 12'h123, 12'h000, 1'b0);

      // Mid-frame position change takes effect next frame.
      pos_x = 10'd200;
      check_px("midframe old", 10'd110, 10'd53, 1'b1, 12'h321, 12'h30A, 1'b1);
      check_px("midframe new", 10'd260, 10'd53, 1'b1, 12'h321, 12'h321, 1'b0);
      frame_start();
      check_px("next new", 10'd260, 10'd53, 1'b1, 12'h321, 12'h33C, 1'b1);
      check_px("next old", 10'd110, 10'd53, 1'b1, 12'h321, 12'h321, 1'b0);

      // 2x at origin.
      pos_x = 10'd0; pos_y = 10'd0; scale = 2'd1;
      frame_start();
      hCount = 10'd5; vCount = 10'd5; #1;
      check_val("rom_col 2x", rom_bus.rom_col, 2);
      check_val("rom_row 2x", rom_bus.rom_row, 2);
      check_px("2x c0", 10'd1, 10'd0, 1'b1, 12'h555, 12'h000, 1'b1);
      check_px("2x c1", 10'd3, 10'd1, 1'b1, 12'h555, 12'h001, 1'b1);
      check_px("2x last", 10'd311, 10'd21, 1'b1, 12'h555, 12'hA9B, 1'b1);
      check_px("2x right", 10'd312, 10'd5, 1'b1, 12'h555, 12'h555, 1'b0);
      check_px("2x bottom", 10'd5, 10'd22, 1'b1, 12'h555, 12'h555, 1'b0);

      // Scale 3 acts as 4x.
      scale = 2'd3;
      frame_start();
      check_px("4x last", 10'd623, 10'd43, 1'b1, 12'h666, 12'hA9B, 1'b1);
      check_px("4x right", 10'd624, 10'd10, 1'b1, 12'h666, 12'h666, 1'b0);
      check_px("4x inner", 10'd9, 10'd9, 1'b1, 12'h666, 12'h202, 1'b1);

      // Colour key and tint.
      rom_mode = 1'b1; pos_x = 10'd100; pos_y = 10'd50; scale = 2'd0;
      tint_en = 1'b1; tint_color = 12'h00F;
      frame_start();
      check_px("key px", 10'd105, 10'd52, 1'b1, 12'h456, 12'h456, 1'b0);
      check_px("tint px", 10'd106, 10'd52, 1'b1, 12'h456, 12'h00F, 1'b1);
      tint_color = 12'hFFF;
      check_px("tint key col", 10'd106, 10'd52, 1'b1, 12'h456, 12'hFFF, 1'b1);
      check_px("tint blank", 10'd106, 10'd52, 1'b0, 12'h456, 12'h000, 1'b0);
      tint_en = 1'b0;
      check_px("untinted", 10'd107, 10'd53, 1'b1, 12'h456, 12'h0F0, 1'b1);

      // Right-edge clipping, no wrap to column 0.
      rom_mode = 1'b0; pos_x = 10'd1000; pos_y = 10'd0; scale = 2'd2;
      frame_start();
      check_px("clip origin", 10'd1000, 10'd1, 1'b1, 12'h789, 12'h000, 1'b1);
      check_px("clip 1023", 10'd1023, 10'd3, 1'b1, 12'h789, 12'h005, 1'b1);
      check_px("no wrap 0", 10'd0, 10'd4, 1'b1, 12'h789, 12'h789, 1'b0);
      check_px("no wrap 10", 10'd10, 10'd4, 1'b1, 12'h789, 12'h789, 1'b0);

      // Blink with a 2-frame half-period.
      pos_x = 10'd100; pos_y = 10'd50; scale = 2'd0;
      frame_start();
      blink_en = 1'b1;
      check_px("blink pre", 10'd110, 10'd53, 1'b1, 12'hABC, 12'h30A, 1'b1);
      for (int i = 0; i < 6; i++) begin
         frame_start();
         check_px($sformatf("blink f%0d", i), 10'd110, 10'd53, 1'b1, 12'hABC,
                  blink_exp[i] ? 12'h30A : 12'hABC, blink_exp[i]);
      end
      blink_en = 1'b0;
      @(posedge clk); #1;
      check_px("blink off", 10'd110, 10'd53, 1'b1, 12'hABC, 12'h30A, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sprite_overlay.md
Name: sprite_overlay

Overview:
Parametrised successor to the fixed-position text/sprite overlay in the VGA path. It draws one ROM-backed sprite over a caller-supplied background. Position and integer scale are runtime-programmable and latched at frame start to prevent tearing. Colour-key transparency, optional tint recolouring, a frame-synchronous blink mode and a pixel-hit flag are added. It sits between the hCount/vCount generator and the VGA rgb pins and can be chained, so one instance's rgb feeds the next instance's background.

Parameters:
SPR_W, 156, sprite width in ROM pixels
SPR_H, 11, sprite height in ROM pixels
ROW_W, 4, ROM row address width (2^ROW_W >= SPR_H)
COL_W, 8, ROM column address width (2^COL_W >= SPR_W)
KEY_COLOR, 12'hFFF, transparent colour key
RST_X, 250, reset value of latched X origin
RST_Y, 250, reset value of latched Y origin
BLINK_FRAMES, 30, frames per blink half-period (>=1)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-low reset
en  in  1  sprite enable (sampled at frame start)
bright  in  1  active-video flag
hCount  in  10  current pixel column
vCount  in  10  current pixel row
pos_x  in  10  requested X origin (sampled at frame start)
pos_y  in  10  requested Y origin (sampled at frame start)
scale  in  2  0=1x, 1=2x, 2=4x, 3=treated as 4x (sampled at frame start)
blink_en  in  1  blink mode enable
tint_en  in  1  replace opaque pixels with tint_color
tint_color  in  12  tint colour
background  in  12  pixel underneath
rom_row  out  ROW_W  ROM row address (combinational)
rom_col  out  COL_W  ROM column address (combinational)
rom_data  in  12  ROM colour, valid one clk after address
rgb  out  12  registered output pixel
sprite_hit  out  1  registered; 1 when rgb is an opaque sprite pixel
frame_tick  out  1  one-clk pulse, registered, at each frame start

Behaviour:
- Reset (rst==0 at a clk edge): rgb=0, sprite_hit=0, frame_tick=0, shadow x/y = RST_X/RST_Y, shadow scale=0, shadow en=0, blink counter=0, visible=1, all pipeline regs cleared. Reset mid-frame: the sprite stays hidden until the next frame start.
- Frame start = cycle where hCount==0 && vCount==0. On that edge, shadow registers load en, pos_x, pos_y and scale (3 maps to 2); frame_tick=1 the following cycle. Input changes at any other time have no effect on the current frame.
- Shift s = shadow scale. Window: hCount in [x, x+(SPR_W<<s)) and vCount in [y, y+(SPR_H<<s)). Compute in 12 bits; no wrap, so any part beyond 1023 is clipped.
- rom_col = ((hCount-x)>>s)[COL_W-1:0], rom_row = ((vCount-y)>>s)[ROW_W-1:0]. Outside the window the value is don't-care.
- Blink: if blink_en==0, counter=0 and visible=1. Otherwise, at each frame start the counter increments; when it equals BLINK_FRAMES-1 it wraps to 0 and visible toggles. Deasserting blink_en forces visible=1 on the next clk.
- Pipeline, latency 2 clk from hCount/vCount/bright/background to rgb:
  - Stage 1 registers on = shadow_en && visible && in_window, together with bright and background. Stage 1 and rom_data align.
  - Stage 2 registers rgb and sprite_hit.
- Stage 2 output:
  - If !bright_d: rgb=0, hit=0.
  - Else if on_d && rom_data!=KEY_COLOR: rgb = tint_en_d ? tint_color_d : rom_data, hit=1. tint_en and tint_color pass through stage 1.
  - Else: rgb=background_d, hit=0.
- A tint_color equal to KEY_COLOR is still drawn; the key test applies only to rom_data.

Test Plan:
1. Reset, then first frame with en=1, pos=(100,50), scale=0 → no sprite in frame 0; in frame 1, rom_col=0 at hCount=100 and rgb=rom_data 2 clk later. At hCount=99 and at 100+156, rgb=background.
2. scale=1, pos=(0,0) → rom_col increments every 2 hCount; window spans hCount 0..311 and vCount 0..21. scale=3 behaves identically to scale=2 (window 624 wide).
3. ROM returns 12'hFFF at one pixel and 12'h0F0 elsewhere, tint_en=1, tint_color=12'h00F → key pixel shows background, all others show 12'h00F with sprite_hit=1. bright=0 → rgb=0 and hit=0.
4. Change pos_x from 100 to 200 mid-frame → the current frame still draws at 100 and the next frame draws at 200.
5. blink_en=1, BLINK_FRAMES=2 → sprite visible for frames 1-2 and hidden for 3-4, repeating. frame_tick pulses exactly once per frame.
6. pos_x=1000, scale=2 → the sprite is clipped at hCount 1023, with no wrap-around drawing at hCount 0..
